regfile_dump_unit: RTL and testbench

Debug read-out engine for the 64-bit LEGv8 register file: on request it halts the core, walks the register file's A read port over a configured index range, and streams each `{index, value}` over a valid/ready interface. It is the reader counterpart to the writeback path that fills the register file, and sits between the register file's `RA`/`BusA` port (muxed in while halted) and the debug/trace link.

---
 rtl/legv8_pkg.sv | 17 +
 rtl/regfile_dump_unit_if.sv | 31 +++
 rtl/regfile_dump_unit.sv | 116 +++++++++++
 tb/tb_regfile_dump_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: register-file geometry and the dump engine's
// state encoding.
package legv8_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned XZR_IDX   = 31;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ADDR,
        SEND,
        DONE
    } dumpState_t;

endpackage

// File: rtl/regfile_dump_unit_if.sv
// Valid/ready stream carrying one {index, value} beat per register.
interface regfile_dump_unit_if
    import legv8_pkg::*;
#(
    parameter int unsigned DATA_W = XLEN,
    parameter int unsigned IDX_W  = REG_IDX_W
) ();

    logic              DumpValid;
    logic              DumpReady;
    logic [DATA_W-1:0] DumpData;
    logic [IDX_W-1:0]  DumpIdx;
    logic              DumpLast;

    modport master (
        output DumpValid,
        output DumpData,
        output DumpIdx,
        output DumpLast,
        input  DumpReady
    );

    modport slave (
        input  DumpValid,
        input  DumpData,
        input  DumpIdx,
        input  DumpLast,
        output DumpReady
    );

endinterface

// File: rtl/regfile_dump_unit.sv
// Debug read-out engine: halts the core, walks the register file A port
// from FIRST_REG to LAST_REG and streams each {index, value} beat.
module regfile_dump_unit
    import legv8_pkg::*;
#(
    parameter int unsigned DATA_W    = XLEN,
    parameter int unsigned IDX_W     = REG_IDX_W,
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 30
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Start,
    output logic                HaltReq,
    input  logic                HaltAck,
    output logic [IDX_W-1:0]    RA,
    input  logic [DATA_W-1:0]   BusA,
    regfile_dump_unit_if.master dumpBus,
    output logic                Busy,
    output logic                Done
);

    localparam logic [IDX_W-1:0] FirstIdx = IDX_W'(FIRST_REG);
    localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(LAST_REG);

    dumpState_t       state;
    dumpState_t       nextState;
    logic [IDX_W-1:0] regIdx;
    logic [IDX_W-1:0] nextIdx;
    logic             atLast;
    logic             beatTaken;

    assign nextIdx   = regIdx + IDX_W'(1);
    assign atLast    = (regIdx == LastIdx);
    assign beatTaken = (state == SEND) && dumpBus.DumpReady;

    // State register; async reset abandons any dump in progress without Done.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode and the state-derived control outputs.
    always_comb begin
        nextState         = state;
        HaltReq           = 1'b0;
        Busy              = 1'b1;
        Done              = 1'b0;
        dumpBus.DumpValid = 1'b0;
        unique case (state)
            IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    nextState = HALT;
                end
            end
            HALT: begin
                HaltReq = 1'b1;
                if (HaltAck) begin
                    nextState = ADDR;
                end
            end
            ADDR: begin
                HaltReq   = 1'b1;
                nextState = SEND;
            end
            SEND: begin
                HaltReq           = 1'b1;
                dumpBus.DumpValid = 1'b1;
                if (dumpBus.DumpReady) begin
                    nextState = atLast ? DONE : ADDR;
                end
            end
            DONE: begin
                Done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Index counter, registered read address and beat capture. RA is loaded
    // on the edge entering ADDR so BusA has the whole ADDR cycle to settle;
    // the counter stops at LAST_REG so it can never wrap.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            regIdx           <= FirstIdx;
            RA               <= '0;
            dumpBus.DumpData <= '0;
            dumpBus.DumpIdx  <= '0;
            dumpBus.DumpLast <= 1'b0;
        end else begin
            if ((state == IDLE) && Start) begin
                regIdx <= FirstIdx;
            end
            if ((state == HALT) && HaltAck) begin
                RA <= regIdx;
            end
            if (beatTaken && !atLast) begin
                regIdx <= nextIdx;
                RA     <= nextIdx;
            end
            if (state == ADDR) begin
                dumpBus.DumpData <= BusA;
                dumpBus.DumpIdx  <= regIdx;
                dumpBus.DumpLast <= atLast;
            end
        end
    end

endmodule

// File: tb/tb_regfile_dump_unit.sv
// Directed bench for regfile_dump_unit: default 0..30 instance and a 5..31
// instance, each reading a register-file model where Xi = i*0x1111, X31 = 0.
module tb_regfile_dump_unit;
    import legv8_pkg::*;

    localparam int unsigned DW = 64;
    localparam int unsigned IW = 5;

    logic          Clk = 1'b0;
    logic          Rst_n;
    logic          startA, haltAckA, haltReqA, busyA, doneA;
    logic          startB, haltAckB, haltReqB, busyB, doneB;
    logic [IW-1:0] raA, raB;
    logic [DW-1:0] busAA, busAB;
    logic [9:0]    readyPat = 10'b0100100100;

    int nCompared   = 0;
    int nMismatched = 0;

    regfile_dump_unit_if #(.DATA_W(DW), .IDX_W(IW)) ifA ();
    regfile_dump_unit_if #(.DATA_W(DW), .IDX_W(IW)) ifB ();

    regfile_dump_unit #(.DATA_W(DW), .IDX_W(IW), .FIRST_REG(0), .LAST_REG(30)) dutA (
        .Clk(Clk), .Rst_n(Rst_n), .Start(startA), .HaltReq(haltReqA), .HaltAck(haltAckA),
        .RA(raA), .BusA(busAA), .dumpBus(ifA.master), .Busy(busyA), .Done(doneA)
    );

    regfile_dump_unit #(.DATA_W(DW), .IDX_W(IW), .FIRST_REG(5), .LAST_REG(31)) dutB (
        .Clk(Clk), .Rst_n(Rst_n), .Start(startB), .HaltReq(haltReqB), .HaltAck(haltAckB),
        .RA(raB), .BusA(busAB), .dumpBus(ifB.master), .Busy(busyB), .Done(doneB)
    );

    always #5 Clk = ~Clk;

    function automatic logic [63:0] regModel(input logic [4:0] idx);
        if (32'(idx) == XZR_IDX) return '0;
        return 64'(idx) * 64'h1111;
    endfunction

    assign busAA = regModel(raA);
    assign busAB = regModel(raB);

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete dump. ackCycle is the cycle (Start raised in cycle 0) whose
    // closing edge first sees HaltAck high; 1 means HaltAck tied high.
    task automatic runDump(input bit useB, input int unsigned firstIdx, input int unsigned lastIdx,
                           input int unsigned ackCycle, input bit stallReady, input bit pokeStart);
        int unsigned nRegs  = lastIdx - firstIdx + 1;
        int unsigned expIdx = firstIdx;
        int unsigned beats  = 0;
        int          doneCycle = -1;
        bit          stalled = 1'b0;
        logic [63:0] heldData = '0;
        logic [4:0]  heldIdx = '0;
        logic        heldLast = 1'b0;
        logic        v, hreq, busy, done, last, sVal, aVal, rVal;
        logic [63:0] data;
        logic [4:0]  idx, ra;

        @(negedge Clk);
        sVal = 1'b1;
        aVal = (ackCycle <= 1);
        rVal = 1'b1;
        if (useB) begin startB = sVal; haltAckB = aVal; ifB.DumpReady = rVal; end
        else begin startA = sVal; haltAckA = aVal; ifA.DumpReady = rVal; end

        for (int c = 1; c < 600; c++) begin
            @(negedge Clk);
            if (useB) begin
                v = ifB.DumpValid; data = ifB.DumpData; idx = ifB.DumpIdx; last = ifB.DumpLast;
                hreq = haltReqB; busy = busyB; done = doneB; ra = raB;
            end else begin
                v = ifA.DumpValid; data = ifA.DumpData; idx = ifA.DumpIdx; last = ifA.DumpLast;
                hreq = haltReqA; busy = busyA; done = doneA; ra = raA;
            end

            if (c == 1) begin
                checkVal("haltReqAfterStart", 64'(hreq), 64'd1);
                checkVal("busyAfterStart", 64'(busy), 64'd1);
            end
            if (c <= int'(ackCycle) + 1)
                checkVal("noValidBeforeAck", 64'(v), 64'd0);
            if (!useB && ackCycle > 1 && c <= int'(ackCycle))
                checkVal("raHeldDuringHalt", 64'(ra), 64'd0);
            if (c == int'(ackCycle) + 1)
                checkVal("raInAddr", 64'(ra), 64'(firstIdx));
            if (c == int'(ackCycle) + 2)
                checkVal("firstValid", 64'(v), 64'd1);

            if (stalled) begin
                checkVal("validHeldInStall", 64'(v), 64'd1);
                checkVal("dataHeldInStall", data, heldData);
                checkVal("idxHeldInStall", 64'(idx), 64'(heldIdx));
                checkVal("lastHeldInStall", 64'(last), 64'(heldLast));
            end

            sVal = pokeStart && v && (beats == 3);
            if (ackCycle > 1 && c == int'(ackCycle)) aVal = 1'b1;
            if (ackCycle > 1 && c == int'(ackCycle) + 3) aVal = 1'b0;
            rVal = stallReady ? readyPat[c % 10] : 1'b1;

            stalled = 1'b0;
            if (v && rVal) begin
                checkVal("beatIdx", 64'(idx), 64'(expIdx));
                checkVal("beatData", data, regModel(5'(expIdx)));
                checkVal("beatLast", 64'(last), 64'(expIdx == lastIdx));
                beats++;
                expIdx++;
            end else if (v) begin
                stalled  = 1'b1;
                heldData = data;
                heldIdx  = idx;
                heldLast = last;
            end

            if (done && doneCycle < 0) begin
                doneCycle = c;
                checkVal("beatCount", 64'(beats), 64'(nRegs));
                checkVal("haltReqAtDone", 64'(hreq), 64'd0);
                if (!stallReady)
                    checkVal("doneCycle", 64'(c), 64'(ackCycle + 2 * nRegs + 1));
            end else if (doneCycle >= 0 && c == doneCycle + 1) begin
                checkVal("donePulseWidth", 64'(done), 64'd0);
                checkVal("busyAfterDone", 64'(busy), 64'd0);
            end else if (doneCycle >= 0 && c == doneCycle + 3) begin
                checkVal("noRestart", 64'(busy), 64'd0);
                break;
            end

            if (useB) begin startB = sVal; haltAckB = aVal; ifB.DumpReady = rVal; end
            else begin startA = sVal; haltAckA = aVal; ifA.DumpReady = rVal; end
        end

        if (doneCycle < 0) checkVal("doneTimeout", 64'd0, 64'd1);
        if (useB) begin startB = 1'b0; ifB.DumpReady = 1'b1; end
        else begin startA = 1'b0; ifA.DumpReady = 1'b1; end
    endtask

    initial begin
        bit found;
        Rst_n = 1'b0;
        startA = 1'b0; haltAckA = 1'b0; ifA.DumpReady = 1'b1;
        startB = 1'b0; haltAckB = 1'b0; ifB.DumpReady = 1'b1;
        repeat (3) @(negedge Clk);

        checkVal("rstHaltReq", 64'(haltReqA), 64'd0);
        checkVal("rstRA", 64'(raA), 64'd0);
        checkVal("rstValid", 64'(ifA.DumpValid), 64'd0);
        checkVal("rstData", ifA.DumpData, 64'd0);
        checkVal("rstIdx", 64'(ifA.DumpIdx), 64'd0);
        checkVal("rstLast", 64'(ifA.DumpLast), 64'd0);
        checkVal("rstBusy", 64'(busyA), 64'd0);
        checkVal("rstDone", 64'(doneA), 64'd0);
        Rst_n = 1'b1;

        runDump(1'b0, 0, 30, 10, 1'b0, 1'b0);
        runDump(1'b0, 0, 30, 1, 1'b0, 1'b0);
        runDump(1'b0, 0, 30, 1, 1'b1, 1'b1);
        runDump(1'b0, 0, 30, 1, 1'b0, 1'b0);
        runDump(1'b1, 5, 31, 1, 1'b1, 1'b0);

        // Asynchronous reset while idx 12 is on the stream.
        @(negedge Clk);
        startA = 1'b1; haltAckA = 1'b1; ifA.DumpReady = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge Clk);
            startA = 1'b0;
            if (ifA.DumpValid && ifA.DumpIdx == 5'd12) begin
                found = 1'b1;
                break;
            end
        end
        checkVal("reachIdx12", 64'(found), 64'd1);
        #2 Rst_n = 1'b0;
        #1;
        checkVal("midRstHaltReq", 64'(haltReqA), 64'd0);
        checkVal("midRstRA", 64'(raA), 64'd0);
        checkVal("midRstValid", 64'(ifA.DumpValid), 64'd0);
        checkVal("midRstData", ifA.DumpData, 64'd0);
        checkVal("midRstIdx", 64'(ifA.DumpIdx), 64'd0);
        checkVal("midRstLast", 64'(ifA.DumpLast), 64'd0);
        checkVal("midRstBusy", 64'(busyA), 64'd0);
        checkVal("midRstDone", 64'(doneA), 64'd0);
        repeat (2) @(negedge Clk);
        checkVal("noDoneInRst", 64'(doneA), 64'd0);
        Rst_n = 1'b1;
        @(negedge Clk);
        checkVal("noDoneAfterRst", 64'(doneA), 64'd0);
        runDump(1'b0, 0, 30, 1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
